// File: rtl/game_load_sequencer_pkg.sv
// Game codes shared by the selector and the load sequencer, plus the
// code-to-ROM-slot map used to place each game in the loader's address space.
package game_load_sequencer_pkg;

    localparam logic [3:0] GameEms        = 4'h0;
    localparam logic [3:0] GameMario      = 4'h1;
    localparam logic [3:0] GameDonkeyKong = 4'h2;
    localparam logic [3:0] GamePacman     = 4'h3;
    localparam logic [3:0] GameGalaga     = 4'h4;
    localparam logic [3:0] GameDefender2  = 4'h5;
    localparam logic [3:0] GameTennis     = 4'h6;
    localparam logic [3:0] GameGolf       = 4'h7;
    localparam logic [3:0] GamePinball    = 4'h8;

    localparam int unsigned NumGameSlots = 9;

    function automatic logic [3:0] game_slot(input logic [3:0] code);
        logic [3:0] slot;
        case (code)
            GameMario:      slot = 4'd1;
            GameDonkeyKong: slot = 4'd2;
            GamePacman:     slot = 4'd3;
            GameGalaga:     slot = 4'd4;
            GameDefender2:  slot = 4'd5;
            GameTennis:     slot = 4'd6;
            GameGolf:       slot = 4'd7;
            GamePinball:    slot = 4'd8;
            default:        slot = 4'd0;
        endcase
        return slot;
    endfunction

    // Unknown codes fold onto EMS so they never look like a distinct selection.
    function automatic logic [3:0] game_canon(input logic [3:0] code);
        return (game_slot(code) == 4'd0) ? GameEms : code;
    endfunction

endpackage

// File: rtl/game_load_sequencer_sync_debounce.sv
// Two-flop synchroniser followed by a stability counter; stable_o rises once
// the synchronised value has held for StableCycles consecutive cycles.
module game_load_sequencer_sync_debounce #(
    parameter int unsigned Width        = 4,
    parameter int unsigned StableCycles = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] code_o,
    output logic             stable_o
);

    localparam int unsigned CntW = (StableCycles > 1) ? $clog2(StableCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

    logic [Width-1:0] sync1_q, sync2_q;
    logic [Width-1:0] cand_q, cand_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign code_o   = cand_q;
    assign stable_o = (cnt_q == CntMax);

endmodule

// File: rtl/game_load_sequencer.sv
// Turns a debounced game-selection change into a console reload: hold the NES
// core in reset, request the ROM load for the new slot, release on ack.
module game_load_sequencer
    import game_load_sequencer_pkg::*;
#(
    parameter int unsigned StableCycles = 1024,
    parameter int unsigned RstCycles    = 16,
    parameter int unsigned AddrW        = 24,
    parameter int unsigned PrgSlotShift = 15,
    parameter int unsigned ChrSlotShift = 13,
    parameter int unsigned AckTimeout   = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       game_i,
    input  logic             load_ack_i,
    output logic             nes_rst_o,
    output logic             load_req_o,
    output logic [3:0]       load_slot_o,
    output logic [AddrW-1:0] prg_base_o,
    output logic [AddrW-1:0] chr_base_o,
    output logic [3:0]       active_game_o,
    output logic             busy_o,
    output logic             load_err_o
);

    typedef enum logic [2:0] {StBoot, StIdle, StHold, StLoad, StRelease} state_e;

    localparam int unsigned HoldW = (RstCycles > 1) ? $clog2(RstCycles) : 1;
    localparam int unsigned AckW  = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(RstCycles - 1);
    localparam logic [AckW-1:0]  AckMax  = AckW'(AckTimeout - 1);

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [AckW-1:0]  ack_cnt_q, ack_cnt_d;
    logic [3:0]       active_q, active_d;
    logic [3:0]       slot_q, slot_d;
    logic             err_q, err_d;
    logic             latch;

    logic [3:0]       cand;
    logic             stable;
    logic [AddrW-1:0] slot_ext;

    game_load_sequencer_sync_debounce #(
        .Width        (4),
        .StableCycles (StableCycles)
    ) u_sync_debounce (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .d_i      (game_i),
        .code_o   (cand),
        .stable_o (stable)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ack_cnt_d  = ack_cnt_q;
        active_d   = active_q;
        slot_d     = slot_q;
        err_d      = err_q;
        latch      = 1'b0;

        unique case (state_q)
            StBoot: begin
                latch = stable;
            end
            StIdle: begin
                latch = stable && (game_canon(cand) != active_q);
            end
            StHold: begin
                if (hold_cnt_q == HoldMax) begin
                    state_d    = StLoad;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StLoad: begin
                if (load_ack_i) begin
                    state_d   = StRelease;
                    err_d     = 1'b0;
                    ack_cnt_d = '0;
                end else if (ack_cnt_q == AckMax) begin
                    // Retry the same slot after another full reset hold.
                    state_d   = StHold;
                    err_d     = 1'b1;
                    ack_cnt_d = '0;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        if (latch) begin
            state_d    = StHold;
            hold_cnt_d = '0;
            active_d   = game_canon(cand);
            slot_d     = game_slot(cand);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StBoot;
            hold_cnt_q <= '0;
            ack_cnt_q  <= '0;
            active_q   <= GameEms;
            slot_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ack_cnt_q  <= ack_cnt_d;
            active_q   <= active_d;
            slot_q     <= slot_d;
            err_q      <= err_d;
        end
    end

    assign slot_ext      = AddrW'(slot_q);
    assign nes_rst_o     = (state_q != StIdle);
    assign busy_o        = (state_q != StIdle);
    assign load_req_o    = (state_q == StLoad);
    assign load_slot_o   = slot_q;
    assign prg_base_o    = slot_ext << PrgSlotShift;
    assign chr_base_o    = slot_ext << ChrSlotShift;
    assign active_game_o = active_q;
    assign load_err_o    = err_q;

endmodule

// File: tb/tb_game_load_sequencer.sv
// Bench for game_load_sequencer: a reference model checked every cycle, a
// slot-map table, hand-written corner sequences and a random phase.
module tb_game_load_sequencer;
    import game_load_sequencer_pkg::*;

    localparam int unsigned StableCycles = 8;
    localparam int unsigned RstCycles    = 4;
    localparam int unsigned AckTimeout   = 20;
    localparam int unsigned AddrW        = 24;

    localparam logic [3:0] KnownCodes [9] = '{GameEms, GameMario, GameDonkeyKong,
        GamePacman, GameGalaga, GameDefender2, GameTennis, GameGolf, GamePinball};

    logic clk, rst, ack;
    logic [3:0] game;
    logic nes_rst, load_req, busy, load_err;
    logic [3:0] load_slot, active_game;
    logic [AddrW-1:0] prg_base, chr_base;

    int n_vec, n_miss;

    game_load_sequencer #(
        .StableCycles (StableCycles),
        .RstCycles    (RstCycles),
        .AddrW        (AddrW),
        .PrgSlotShift (15),
        .ChrSlotShift (13),
        .AckTimeout   (AckTimeout)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .game_i        (game),
        .load_ack_i    (ack),
        .nes_rst_o     (nes_rst),
        .load_req_o    (load_req),
        .load_slot_o   (load_slot),
        .prg_base_o    (prg_base),
        .chr_base_o    (chr_base),
        .active_game_o (active_game),
        .busy_o        (busy),
        .load_err_o    (load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phases with durations; debounce judged from the input history.
    localparam int PBoot = 0, PIdle = 1, PHold = 2, PLoad = 3, PRel = 4;
    int m_phase, m_timer;
    logic [3:0] m_active, m_slot;
    logic m_err;
    int hist[$];

    function automatic int slot_of(input logic [3:0] code);
        for (int i = 0; i < 9; i++) if (code == KnownCodes[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_latch(input int cand);
        m_slot   = 4'(slot_of(4'(cand)));
        m_active = KnownCodes[m_slot];
        m_phase  = PHold;
        m_timer  = 0;
    endtask

    task automatic model_step();
        bit stable;
        int cand, n;
        if (rst) begin
            m_phase = PBoot; m_timer = 0; m_active = GameEms; m_slot = 0; m_err = 0;
            hist.delete();
            repeat (7) hist.push_back(-1);
            repeat (3) hist.push_back(0);
        end else begin
            n = hist.size();
            cand = hist[n-3];
            stable = 1;
            for (int k = 2; k <= 9; k++) if (hist[n-1-k] != cand) stable = 0;
            case (m_phase)
                PBoot: if (stable) model_latch(cand);
                PIdle: if (stable && KnownCodes[slot_of(4'(cand))] != m_active) model_latch(cand);
                PHold: begin
                    m_timer++;
                    if (m_timer == RstCycles) begin m_phase = PLoad; m_timer = 0; end
                end
                PLoad: begin
                    m_timer++;
                    if (ack) begin m_phase = PRel; m_err = 0; m_timer = 0; end
                    else if (m_timer == AckTimeout) begin m_phase = PHold; m_err = 1; m_timer = 0; end
                end
                default: m_phase = PIdle;
            endcase
            hist.push_back(int'(game));
            if (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("m_nes_rst", nes_rst, m_phase != PIdle);
        chk("m_busy", busy, m_phase != PIdle);
        chk("m_load_req", load_req, m_phase == PLoad);
        chk("m_load_slot", load_slot, m_slot);
        chk("m_prg_base", prg_base, (m_slot * 32768) % (1 << AddrW));
        chk("m_chr_base", chr_base, (m_slot * 8192) % (1 << AddrW));
        chk("m_active_game", active_game, m_active);
        chk("m_load_err", load_err, m_err);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (!load_req && n < budget) begin tick(); n++; end
        chk("req_seen", load_req, 1);
    endtask

    task automatic ack_and_idle();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("release_nes_rst", nes_rst, 1);
        chk("release_req_low", load_req, 0);
        tick();
        chk("idle_nes_rst", nes_rst, 0);
        chk("idle_busy", busy, 0);
    endtask

    typedef struct {
        logic [3:0]       code;
        bit               reload;
        logic [3:0]       slot;
        logic [3:0]       active;
        logic [AddrW-1:0] prg;
        logic [AddrW-1:0] chr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n, seg_len, ack_pct;
        logic [3:0] picks [5];
        n_vec = 0; n_miss = 0;

        tbl[0]  = '{GameEms,        1'b1, 4'd0, GameEms,        24'h000000, 24'h000000};
        tbl[1]  = '{4'hF,           1'b0, 4'd0, GameEms,        24'h000000, 24'h000000};
        tbl[2]  = '{GameMario,      1'b1, 4'd1, GameMario,      24'h008000, 24'h002000};
        tbl[3]  = '{GameDonkeyKong, 1'b1, 4'd2, GameDonkeyKong, 24'h010000, 24'h004000};
        tbl[4]  = '{GamePacman,     1'b1, 4'd3, GamePacman,     24'h018000, 24'h006000};
        tbl[5]  = '{GameGalaga,     1'b1, 4'd4, GameGalaga,     24'h020000, 24'h008000};
        tbl[6]  = '{GameDefender2,  1'b1, 4'd5, GameDefender2,  24'h028000, 24'h00A000};
        tbl[7]  = '{GameTennis,     1'b1, 4'd6, GameTennis,     24'h030000, 24'h00C000};
        tbl[8]  = '{GameGolf,       1'b1, 4'd7, GameGolf,       24'h038000, 24'h00E000};
        tbl[9]  = '{GamePinball,    1'b1, 4'd8, GamePinball,    24'h040000, 24'h010000};
        tbl[10] = '{4'hA,           1'b1, 4'd0, GameEms,        24'h000000, 24'h000000};
        tbl[11] = '{4'hF,           1'b0, 4'd0, GameEms,        24'h000000, 24'h000000};

        // Boot: reset for 3 cycles, then MARIO.
        rst = 1'b1; game = GameEms; ack = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        tick(); tick();
        chk("rst_nes_rst", nes_rst, 1);
        chk("rst_busy", busy, 1);
        rst = 1'b0; game = GameMario;
        n = 0;
        while (!load_req && n < 40) begin
            chk("boot_nes_rst", nes_rst, 1);
            tick(); n++;
        end
        chk("boot_req", load_req, 1);
        chk("boot_slot", load_slot, 1);
        chk("boot_prg", prg_base, 24'h008000);
        chk("boot_chr", chr_base, 24'h002000);
        tick();
        ack_and_idle();

        // Bounce: MARIO<->GALAGA every 5 cycles never settles long enough.
        for (int s = 0; s < 12; s++) begin
            game = (s % 2 == 0) ? GameGalaga : GameMario;
            repeat (5) begin tick(); chk("bounce_nes_rst", nes_rst, 0); end
        end
        game = GameMario;
        repeat (20) begin tick(); chk("settle_busy", busy, 0); end

        // Switch to PINBALL.
        game = GamePinball;
        n = 0;
        while (!nes_rst && n < 20) begin tick(); n++; end
        chk("switch_latency_le11", int'(nes_rst && n <= 11), 1);
        wait_req(10, n);
        chk("switch_hold_cycles", n, 4);
        chk("switch_slot", load_slot, 8);
        chk("switch_prg", prg_base, 24'h040000);
        chk("switch_chr", chr_base, 24'h010000);
        ack_and_idle();

        // Slot-map table.
        for (int i = 0; i < 12; i++) begin
            game = tbl[i].code;
            if (tbl[i].reload) begin
                wait_req(40, n);
                chk("tbl_slot", load_slot, tbl[i].slot);
                chk("tbl_prg", prg_base, tbl[i].prg);
                chk("tbl_chr", chr_base, tbl[i].chr);
                chk("tbl_active", active_game, tbl[i].active);
                ack_and_idle();
            end else begin
                repeat (20) begin tick(); chk("tbl_noreload_busy", busy, 0); end
                chk("tbl_active", active_game, tbl[i].active);
            end
        end

        // Timeout: no ack for a full window, then retry.
        game = GameMario;
        wait_req(40, n);
        n = 0;
        while (load_req && n < 40) begin n++; tick(); end
        chk("timeout_req_cycles", n, 20);
        chk("timeout_err", load_err, 1);
        n = 0;
        while (!load_req && n < 10) begin
            chk("retry_nes_rst", nes_rst, 1);
            n++; tick();
        end
        chk("retry_hold_cycles", n, 4);
        chk("retry_slot", load_slot, 1);
        ack_and_idle();
        chk("retry_err_clear", load_err, 0);

        // Reset while loading restarts the boot sequence.
        game = GameGalaga;
        wait_req(40, n);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstload_req", load_req, 0);
        chk("rstload_nes_rst", nes_rst, 1);
        chk("rstload_active", active_game, GameEms);
        wait_req(40, n);
        chk("reboot_slot", load_slot, 4);
        chk("reboot_prg", prg_base, 24'h020000);
        ack_and_idle();

        // Random phase against the model.
        picks = '{GameMario, GameGalaga, GameEms, 4'hF, GamePinball};
        for (int i = 0; i < 150; i++) begin
            game = picks[$urandom_range(0, 4)];
            seg_len = $urandom_range(1, 30);
            ack_pct = $urandom_range(0, 3) * 15;
            repeat (seg_len) begin
                ack = ($urandom_range(0, 99) < ack_pct);
                rst = ($urandom_range(0, 399) == 0);
                tick();
            end
        end
        rst = 1'b0; ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
